// File: rtl/nes_bus_pkg.sv
// Shared CPU-bus definitions: OAM DMA state encoding and the register
// addresses that the DMA engine and its neighbours decode.
package nes_bus_pkg;

   // Sprite DMA sequencer states
   typedef enum logic [2:0] {
      DMA_IDLE  = 3'd0,
      DMA_HALT  = 3'd1,
      DMA_ALIGN = 3'd2,
      DMA_READ  = 3'd3,
      DMA_WRITE = 3'd4
   } dma_state_e;

   // CPU write here with the source page number to start a sprite DMA
   localparam logic [15:0] ADDR_OAM_DMA    = 16'h4014;
   // PPU OAM data port, the destination of every DMA write
   localparam logic [15:0] ADDR_OAM_DATA   = 16'h2004;
   // APU status register, adjacent to the trigger and must not start a DMA
   localparam logic [15:0] ADDR_APU_STATUS = 16'h4015;

endpackage

// File: rtl/nes_oam_dma.sv
// Sprite (OAM) DMA engine: on a CPU write to the trigger address it takes the
// bus, copies 256 bytes from page {page,00..FF} into the OAM data port, and
// releases the bus. Every state change is gated by the CPU-cycle strobe.
module nes_oam_dma
   import nes_bus_pkg::*;
#(
   parameter logic [15:0] TRIG_ADDR = ADDR_OAM_DMA,
   parameter logic [15:0] OAM_ADDR  = ADDR_OAM_DATA
) (
   input  logic        i_clk,
   input  logic        i_rstn,
   input  logic        i_cyc_en,
   input  logic [15:0] i_bus_addr,
   input  logic [7:0]  i_bus_wdata,
   input  logic        i_bus_wn,
   output logic        o_spr_req,
   input  logic        i_spr_gnt,
   output logic [15:0] o_spr_addr,
   output logic        o_spr_wn,
   output logic [7:0]  o_spr_wdata,
   input  logic [7:0]  i_spr_rdata,
   output logic        o_busy
);

   dma_state_e  state_q, state_d;
   logic [7:0]  page_q, page_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [7:0]  data_q, data_d;
   logic        parity_q;
   logic        trigger;

   // A CPU write of the page number to the trigger address
   assign trigger = i_cyc_en & ~i_bus_wn & (i_bus_addr == TRIG_ADDR);

   // Busy is simply the bus request seen from the CPU side
   assign o_busy = o_spr_req;

   // CPU-cycle parity decides whether an extra alignment cycle is needed
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         parity_q <= 1'b0;
      end else if (i_cyc_en) begin
         parity_q <= ~parity_q;
      end
   end

   // Sequencer state, source page, byte counter and the byte in flight
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q <= DMA_IDLE;
         page_q  <= 8'h00;
         cnt_q   <= 8'h00;
         data_q  <= 8'h00;
      end else begin
         state_q <= state_d;
         page_q  <= page_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
      end
   end

   // Next-state and bus outputs; a stalled access (no grant) holds everything
   always_comb begin
      state_d     = state_q;
      page_d      = page_q;
      cnt_d       = cnt_q;
      data_d      = data_q;
      o_spr_req   = 1'b1;
      o_spr_addr  = 16'h0000;
      o_spr_wn    = 1'b1;
      o_spr_wdata = 8'h00;

      case (state_q)
         DMA_IDLE: begin
            o_spr_req = 1'b0;
            if (trigger) begin
               page_d  = i_bus_wdata;
               cnt_d   = 8'h00;
               state_d = DMA_HALT;
            end
         end
         DMA_HALT: begin
            if (i_cyc_en) begin
               state_d = parity_q ? DMA_ALIGN : DMA_READ;
            end
         end
         DMA_ALIGN: begin
            if (i_cyc_en) begin
               state_d = DMA_READ;
            end
         end
         DMA_READ: begin
            o_spr_addr = {page_q, cnt_q};
            if (i_cyc_en && i_spr_gnt) begin
               data_d  = i_spr_rdata;
               state_d = DMA_WRITE;
            end
         end
         DMA_WRITE: begin
            o_spr_addr  = OAM_ADDR;
            o_spr_wn    = 1'b0;
            o_spr_wdata = data_q;
            if (i_cyc_en && i_spr_gnt) begin
               cnt_d   = cnt_q + 8'd1;
               state_d = (cnt_q == 8'hFF) ? DMA_IDLE : DMA_READ;
            end
         end
         default: begin
            state_d = DMA_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_nes_oam_dma.sv
// Self-checking bench for the sprite DMA engine: a scoreboard of expected
// read addresses and copied bytes, driven from a table of transfer scenarios.
module tb_nes_oam_dma;
   import nes_bus_pkg::*;

   logic        i_clk;
   logic        i_rstn;
   logic        i_cyc_en;
   logic [15:0] i_bus_addr;
   logic [7:0]  i_bus_wdata;
   logic        i_bus_wn;
   logic        o_spr_req;
   logic        i_spr_gnt;
   logic [15:0] o_spr_addr;
   logic        o_spr_wn;
   logic [7:0]  o_spr_wdata;
   logic [7:0]  i_spr_rdata;
   logic        o_busy;

   typedef struct {
      logic [7:0] page;
      logic       haltPar;
      logic       randEn;
      logic       stall;
      logic       midTrig;
      int         expReq;
   } dmaVec_t;

   typedef struct {
      logic [15:0] addr;
      logic        wn;
      logic [7:0]  data;
   } idleVec_t;

   int          total;
   int          bad;
   int          reqCount;
   int          stallDone;
   logic        par;
   logic        lastEn;
   logic        forceEn;
   logic        randEn;
   logic        stallArm;
   logic [7:0]  curPage;
   logic [15:0] lastRead;
   logic [15:0] expAddrQ[$];
   logic [7:0]  dataQ[$];

   nes_oam_dma dut (
      .i_clk       (i_clk),
      .i_rstn      (i_rstn),
      .i_cyc_en    (i_cyc_en),
      .i_bus_addr  (i_bus_addr),
      .i_bus_wdata (i_bus_wdata),
      .i_bus_wn    (i_bus_wn),
      .o_spr_req   (o_spr_req),
      .i_spr_gnt   (i_spr_gnt),
      .o_spr_addr  (o_spr_addr),
      .o_spr_wn    (o_spr_wn),
      .o_spr_wdata (o_spr_wdata),
      .i_spr_rdata (i_spr_rdata),
      .o_busy      (o_busy)
   );

   // Free-running system clock
   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Memory contents seen by DMA reads: a fixed scramble of the address
   function automatic logic [7:0] memVal(input logic [15:0] a);
      return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA5;
   endfunction

   assign i_spr_rdata = memVal(o_spr_addr);

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic flagFail(input string name, input logic [31:0] act);
      total++;
      bad++;
      $display("[TB] FAIL %s: got %h want nothing at %0t", name, act, $time);
   endtask

   // Mid-cycle scoreboard: reads pop expected addresses and push expected data,
   // writes pop expected data; stalled accesses must repeat the same access.
   task automatic observe();
      lastEn = i_cyc_en;
      if (i_rstn) begin
         checkOutput("busy_follows_req", {31'd0, o_busy}, {31'd0, o_spr_req});
         if (!o_spr_req) begin
            checkOutput("idle_bus", {7'd0, o_spr_addr, o_spr_wn, o_spr_wdata}, {7'd0, 16'h0000, 1'b1, 8'h00});
         end
         if (i_cyc_en && o_spr_req) reqCount++;
         if (i_cyc_en && o_spr_req && o_spr_wn && o_spr_addr != 16'h0000) begin
            if (expAddrQ.size() == 0) begin
               flagFail("unexpected_read", {16'd0, o_spr_addr});
            end else if (i_spr_gnt) begin
               checkOutput("read_addr", {16'd0, o_spr_addr}, {16'd0, expAddrQ.pop_front()});
               dataQ.push_back(memVal(o_spr_addr));
               lastRead = o_spr_addr;
            end else begin
               checkOutput("reissue_addr", {16'd0, o_spr_addr}, {16'd0, expAddrQ[0]});
            end
         end
         if (i_cyc_en && o_spr_req && !o_spr_wn) begin
            checkOutput("write_addr", {16'd0, o_spr_addr}, {16'd0, ADDR_OAM_DATA});
            if (dataQ.size() == 0) begin
               flagFail("unexpected_write", {24'd0, o_spr_wdata});
            end else if (i_spr_gnt) begin
               checkOutput("write_data", {24'd0, o_spr_wdata}, {24'd0, dataQ.pop_front()});
            end else begin
               checkOutput("reissue_data", {24'd0, o_spr_wdata}, {24'd0, dataQ[0]});
            end
         end
      end
   endtask

   // Pick strobe and grant for the coming cycle; grant is withheld four enabled
   // cycles on the read of offset 0x10 when a stall is armed.
   task automatic drive();
      i_cyc_en = (forceEn || !randEn) ? 1'b1 : ($urandom_range(0, 1) != 0);
      if (stallArm && i_cyc_en && o_spr_req && o_spr_wn &&
          o_spr_addr == {curPage, 8'h10} && stallDone < 4) begin
         i_spr_gnt = 1'b0;
         stallDone++;
      end else begin
         i_spr_gnt = 1'b1;
      end
   endtask

   // One clock: observe mid-cycle, track parity at the edge, drive just after
   task automatic tick();
      @(negedge i_clk);
      observe();
      @(posedge i_clk);
      if (!i_rstn) par = 1'b0;
      else if (lastEn) par = ~par;
      #1;
      drive();
   endtask

   // One CPU bus cycle, optionally placed where the current parity equals wantPar
   task automatic applyStimulus(input logic [15:0] addr, input logic wn,
                                input logic [7:0] data, input int wantPar);
      int guard;
      guard = 0;
      forceEn = 1'b1;
      tick();
      while (wantPar >= 0 && par != wantPar[0] && guard < 10) begin
         tick();
         guard++;
      end
      if (guard >= 10) flagFail("parity_align_timeout", guard);
      i_bus_addr  = addr;
      i_bus_wn    = wn;
      i_bus_wdata = data;
      tick();
      i_bus_addr  = 16'h0000;
      i_bus_wn    = 1'b1;
      i_bus_wdata = 8'h00;
      forceEn     = 1'b0;
   endtask

   task automatic armTransfer(input logic [7:0] page);
      curPage  = page;
      lastRead = 16'h0000;
      reqCount = 0;
      expAddrQ.delete();
      dataQ.delete();
      for (int i = 0; i < 256; i++) expAddrQ.push_back({page, i[7:0]});
   endtask

   task automatic waitIdle(input int budget);
      int n;
      n = 0;
      while (o_spr_req && n < budget) begin
         tick();
         n++;
      end
      if (n >= budget) flagFail("dma_timeout", n);
   endtask

   dmaVec_t  dmaTab[6];
   idleVec_t idleTab[4];

   initial begin
      dmaTab[0] = '{page: 8'h02, haltPar: 1'b0, randEn: 1'b0, stall: 1'b0, midTrig: 1'b0, expReq: 513};
      dmaTab[1] = '{page: 8'h02, haltPar: 1'b1, randEn: 1'b0, stall: 1'b0, midTrig: 1'b0, expReq: 514};
      dmaTab[2] = '{page: 8'h02, haltPar: 1'b0, randEn: 1'b0, stall: 1'b1, midTrig: 1'b0, expReq: 517};
      dmaTab[3] = '{page: 8'h5C, haltPar: 1'b1, randEn: 1'b1, stall: 1'b0, midTrig: 1'b0, expReq: 514};
      dmaTab[4] = '{page: 8'h71, haltPar: 1'b0, randEn: 1'b0, stall: 1'b0, midTrig: 1'b1, expReq: 513};
      dmaTab[5] = '{page: 8'hFF, haltPar: 1'b1, randEn: 1'b0, stall: 1'b0, midTrig: 1'b0, expReq: 514};

      idleTab[0] = '{addr: ADDR_APU_STATUS, wn: 1'b0, data: 8'h02};
      idleTab[1] = '{addr: ADDR_OAM_DMA,    wn: 1'b1, data: 8'h02};
      idleTab[2] = '{addr: ADDR_OAM_DATA,   wn: 1'b0, data: 8'h02};
      idleTab[3] = '{addr: 16'h4013,        wn: 1'b0, data: 8'h02};

      total = 0; bad = 0; reqCount = 0; stallDone = 0;
      par = 1'b0; lastEn = 1'b0; forceEn = 1'b0; randEn = 1'b0; stallArm = 1'b0;
      curPage = 8'h00; lastRead = 16'h0000;
      i_rstn = 1'b0; i_cyc_en = 1'b0; i_spr_gnt = 1'b1;
      i_bus_addr = 16'h0000; i_bus_wn = 1'b1; i_bus_wdata = 8'h00;

      #2;
      checkOutput("reset_req", {31'd0, o_spr_req}, 32'd0);
      checkOutput("reset_busy", {31'd0, o_busy}, 32'd0);
      checkOutput("reset_bus", {7'd0, o_spr_addr, o_spr_wn, o_spr_wdata}, {7'd0, 16'h0000, 1'b1, 8'h00});
      repeat (2) @(posedge i_clk);
      #3 i_rstn = 1'b1;
      par = 1'b0;
      repeat (3) tick();

      for (int v = 0; v < 4; v++) begin
         reqCount = 0;
         applyStimulus(idleTab[v].addr, idleTab[v].wn, idleTab[v].data, -1);
         repeat (3) tick();
         checkOutput("no_trigger_req", {31'd0, o_spr_req}, 32'd0);
         checkOutput("no_trigger_cycles", reqCount, 32'd0);
      end

      for (int v = 0; v < 6; v++) begin
         armTransfer(dmaTab[v].page);
         randEn    = dmaTab[v].randEn;
         stallArm  = dmaTab[v].stall;
         stallDone = 0;
         applyStimulus(ADDR_OAM_DMA, 1'b0, dmaTab[v].page, dmaTab[v].haltPar ? 0 : 1);
         if (dmaTab[v].midTrig) begin
            repeat (20) tick();
            applyStimulus(ADDR_OAM_DMA, 1'b0, 8'h33, -1);
         end
         waitIdle(4000);
         randEn   = 1'b0;
         stallArm = 1'b0;
         checkOutput("req_cycles", reqCount, dmaTab[v].expReq);
         checkOutput("reads_left", expAddrQ.size(), 32'd0);
         checkOutput("writes_left", dataQ.size(), 32'd0);
         checkOutput("last_read", {16'd0, lastRead}, {16'd0, dmaTab[v].page, 8'hFF});
         if (dmaTab[v].stall) checkOutput("stall_cycles", stallDone, 32'd4);
         repeat (3) tick();
      end

      // Reset pulse while the byte read from offset 0x80 is being written
      armTransfer(8'h03);
      applyStimulus(ADDR_OAM_DMA, 1'b0, 8'h03, 1);
      begin
         int n;
         n = 0;
         while (!(o_spr_req && !o_spr_wn && lastRead == 16'h0380) && n < 1000) begin
            tick();
            n++;
         end
         if (n >= 1000) flagFail("reach_write_80_timeout", n);
      end
      #1 i_rstn = 1'b0;
      #1;
      checkOutput("async_reset_req", {31'd0, o_spr_req}, 32'd0);
      checkOutput("async_reset_busy", {31'd0, o_busy}, 32'd0);
      checkOutput("async_reset_bus", {7'd0, o_spr_addr, o_spr_wn, o_spr_wdata}, {7'd0, 16'h0000, 1'b1, 8'h00});
      expAddrQ.delete();
      dataQ.delete();
      par = 1'b0;
      repeat (2) tick();
      #2 i_rstn = 1'b1;
      reqCount = 0;
      repeat (600) tick();
      checkOutput("post_reset_cycles", reqCount, 32'd0);

      // A fresh transfer after the aborted one starts from offset 0
      armTransfer(8'h04);
      applyStimulus(ADDR_OAM_DMA, 1'b0, 8'h04, 1);
      waitIdle(2000);
      checkOutput("fresh_req_cycles", reqCount, 32'd513);
      checkOutput("fresh_reads_left", expAddrQ.size(), 32'd0);
      checkOutput("fresh_last_read", {16'd0, lastRead}, {16'd0, 16'h04FF});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
